// File: rtl/micro_pkg.sv
// ============================================================================
// micro_pkg : shared types for the microprocessor and its memory dump reader
// Rev 1.0
// ============================================================================
`default_nettype none

package micro_pkg;

  localparam int ADDR_W_DEFAULT = 7;
  localparam int DATA_W_DEFAULT = 24;

  typedef logic [23:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2,
    DONE   = 2'd3
  } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// ============================================================================
// rise_detect : one-cycle pulse on the rising edge of a level input
// Rev 1.0
// ============================================================================
`default_nettype none

module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

`default_nettype wire

// File: rtl/mem_dump_reader.sv
// ============================================================================
// mem_dump_reader : walks select_mem over a window and streams addr/data pairs
// Optional build macro: MEM_DUMP_SKIP_ZERO_EN (zero words are not presented)
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_dump_reader
  import micro_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 127,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              program_done_flag,
  input  logic [DATA_W-1:0] output_mem_cell,
  output logic [ADDR_W-1:0] select_mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
  localparam logic [2:0]        LAT     = 3'(READ_LAT);

  dump_state_t       state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, out_addr_n;
  logic [DATA_W-1:0] out_data_n;
  logic [2:0]        cnt, cnt_n;
  logic              out_valid_n;
  logic              flag_rise, armed, start, skip, advance;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .d     (program_done_flag),
    .rise  (flag_rise)
  );

  // A flag already high when reset releases must be seen low before it can start a dump.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 armed <= 1'b0;
    else if (!program_done_flag) armed <= 1'b1;
  end

  assign start = flag_rise & armed;

`ifdef MEM_DUMP_SKIP_ZERO_EN
  assign skip = (output_mem_cell == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= FIRST_A;
      cnt       <= 3'd0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      cnt       <= cnt_n;
      out_valid <= out_valid_n;
      out_addr  <= out_addr_n;
      out_data  <= out_data_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    cnt_n       = cnt;
    out_valid_n = out_valid;
    out_addr_n  = out_addr;
    out_data_n  = out_data;
    advance     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          addr_n  = FIRST_A;
          cnt_n   = LAT;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt != 3'd0) begin
          cnt_n = cnt - 3'd1;
        end else if (skip) begin
          advance = 1'b1;
        end else begin
          out_valid_n = 1'b1;
          out_addr_n  = addr;
          out_data_n  = output_mem_cell;
          state_n     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          advance     = 1'b1;
        end
      end
      DONE: begin
        if (!program_done_flag) state_n = IDLE;
      end
    endcase

    // The address is never incremented past the last cell, so it cannot wrap.
    if (advance) begin
      if (addr == LAST_A) begin
        state_n = DONE;
      end else begin
        addr_n  = addr + ADDR_W'(1);
        cnt_n   = LAT;
        state_n = SETTLE;
      end
    end
  end

  assign select_mem = (state == IDLE) ? FIRST_A : addr;
  assign busy       = (state == SETTLE) || (state == HOLD);
  assign dump_done  = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
// ============================================================================
// tb_mem_dump_reader : scoreboard bench for mem_dump_reader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_dump_reader;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 24;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flag = 1'b0;
  logic ready = 1'b1;
  logic [DATA_W-1:0] mem_cell;
  logic [ADDR_W-1:0] sel, o_addr;
  logic [DATA_W-1:0] o_data;
  logic o_valid, busy, done;

  logic flag2 = 1'b0;
  logic [ADDR_W-1:0] sel2, o_addr2;
  logic [DATA_W-1:0] o_data2, mem_cell2;
  logic o_valid2, busy2, done2;

  logic [DATA_W-1:0] mem [128];
  vec_t vecs [4];
  vec_t exp_q [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_count = 0;
  int last_hs_cyc = 0;
  int stall_left = 0;
  logic stall_en = 1'b0;
  logic stall_active = 1'b0;
  logic check_interval = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_cell <= mem[sel];
  assign mem_cell2 = mem[sel2];

  mem_dump_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIRST_ADDR(28), .LAST_ADDR(31), .READ_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .program_done_flag(flag), .output_mem_cell(mem_cell),
    .select_mem(sel), .out_valid(o_valid), .out_ready(ready), .out_addr(o_addr),
    .out_data(o_data), .busy(busy), .dump_done(done)
  );

  mem_dump_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIRST_ADDR(127), .LAST_ADDR(127), .READ_LAT(0)
  ) dut2 (
    .clk(clk), .reset(reset), .program_done_flag(flag2), .output_mem_cell(mem_cell2),
    .select_mem(sel2), .out_valid(o_valid2), .out_ready(1'b1), .out_addr(o_addr2),
    .out_data(o_data2), .busy(busy2), .dump_done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int push_expected();
    int n = 0;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_DUMP_SKIP_ZERO_EN
      if (vecs[i].data != '0) begin
        exp_q.push_back(vecs[i]);
        n++;
      end
`else
      exp_q.push_back(vecs[i]);
      n++;
`endif
    end
    return n;
  endfunction

  // Sink: drives ready for the next edge and scores every handshake it will make.
  always @(negedge clk) begin
    vec_t rec;
    if (stall_en && stall_left > 0 && (stall_active || (o_valid && o_addr == 7'd30))) begin
      stall_active = 1'b1;
      ready = 1'b0;
      check("stall_valid", {31'd0, o_valid}, 32'd1);
      check("stall_addr", {25'd0, o_addr}, 32'd30);
      check("stall_data", {8'd0, o_data}, 32'd20);
      check("stall_select", {25'd0, sel}, 32'd30);
      stall_left--;
    end else begin
      stall_active = 1'b0;
      ready = 1'b1;
    end
    if (o_valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got addr=%0d data=%0d, expected no word", o_addr, o_data);
      end else begin
        rec = exp_q.pop_front();
        check("word_addr", {25'd0, o_addr}, {25'd0, rec.addr});
        check("word_data", {8'd0, o_data}, {8'd0, rec.data});
      end
`ifndef MEM_DUMP_SKIP_ZERO_EN
      if (check_interval && hs_count > 0 && exp_q.size() < 3)
        check("word_interval", cyc - last_hs_cyc, 32'd3);
`endif
      last_hs_cyc = cyc;
      hs_count++;
    end
  end

  task automatic wait_done(input string name);
    int guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n_exp, hs0, start_cyc, guard;

    vecs[0] = '{addr: 7'd28, data: 24'd5};
    vecs[1] = '{addr: 7'd29, data: 24'd0};
    vecs[2] = '{addr: 7'd30, data: 24'd20};
    vecs[3] = '{addr: 7'd31, data: 24'd9};
    for (int i = 0; i < 128; i++) mem[i] = 24'(i * 3 + 1);
    for (int i = 0; i < 4; i++) mem[vecs[i].addr] = vecs[i].data;
    mem[127] = 24'hABCDEF;

    // Reset values, with the flag already high.
    flag = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_addr", {25'd0, o_addr}, 32'd0);
    check("rst_data", {8'd0, o_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_select", {25'd0, sel}, 32'd28);
    @(posedge clk); #1 reset = 1'b1;

    // Flag high out of reset is not an edge.
    repeat (10) @(negedge clk);
    check("no_start_busy", {31'd0, busy}, 32'd0);
    check("no_start_done", {31'd0, done}, 32'd0);

    // Basic dump with ready high.
    @(posedge clk); #1 flag = 1'b0;
    repeat (2) @(posedge clk);
    n_exp = push_expected();
    check_interval = 1'b1;
    #1 flag = 1'b1;
    start_cyc = cyc;
    guard = 0;
    @(negedge clk);
    while (!o_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
`ifndef MEM_DUMP_SKIP_ZERO_EN
    check("first_latency", cyc - start_cyc, 32'd3);
`endif
    wait_done("dump1_done");
    check("dump1_empty", exp_q.size(), 32'd0);
    check("dump1_busy", {31'd0, busy}, 32'd0);
    check("dump1_select", {25'd0, sel}, 32'd31);
    check_interval = 1'b0;
    @(posedge clk); #1 flag = 1'b0;
    repeat (2) @(negedge clk);
    check("done_clears", {31'd0, done}, 32'd0);

    // Back-pressure on word 30.
    n_exp = push_expected();
    stall_en = 1'b1;
    stall_left = 10;
    @(posedge clk); #1 flag = 1'b1;
    wait_done("dump2_done");
    check("stall_consumed", stall_left, 32'd0);
    check("dump2_empty", exp_q.size(), 32'd0);
    stall_en = 1'b0;
    @(posedge clk); #1 flag = 1'b0;
    repeat (2) @(posedge clk);

    // Flag dropped mid-dump and pulsed again while busy.
    hs0 = hs_count;
    n_exp = push_expected();
    #1 flag = 1'b1;
    repeat (4) @(posedge clk);
    #1 flag = 1'b0;
    repeat (2) @(posedge clk);
    #1 flag = 1'b1;
    repeat (2) @(posedge clk);
    #1 flag = 1'b0;
    wait_done("dump3_done");
    repeat (20) @(negedge clk);
    check("dump3_words", hs_count - hs0, n_exp);
    check("dump3_empty", exp_q.size(), 32'd0);
    check("dump3_idle_busy", {31'd0, busy}, 32'd0);
    check("dump3_idle_done", {31'd0, done}, 32'd0);

    // Asynchronous reset while holding a word.
    n_exp = push_expected();
    stall_en = 1'b1;
    stall_left = 100;
    @(posedge clk); #1 flag = 1'b1;
    guard = 0;
    while (stall_left > 97 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("hold_reached", {31'd0, o_valid & busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_valid", {31'd0, o_valid}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_done", {31'd0, done}, 32'd0);
    check("async_select", {25'd0, sel}, 32'd28);
    stall_en = 1'b0;
    stall_left = 0;
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b1;
    flag = 1'b0;
    repeat (3) @(posedge clk);

    // Single-cell window at the top of the address space, zero read latency.
    #1 flag2 = 1'b1;
    start_cyc = cyc;
    guard = 0;
    @(negedge clk);
    while (!o_valid2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("top_latency", cyc - start_cyc, 32'd2);
    check("top_addr", {25'd0, o_addr2}, 32'd127);
    check("top_data", {8'd0, o_data2}, 32'h00ABCDEF);
    @(negedge clk);
    check("top_done", {31'd0, done2}, 32'd1);
    check("top_valid_drop", {31'd0, o_valid2}, 32'd0);
    check("top_busy", {31'd0, busy2}, 32'd0);
    check("top_select", {25'd0, sel2}, 32'd127);
    @(posedge clk); #1 flag2 = 1'b0;
    repeat (3) @(negedge clk);
    check("top_done_clears", {31'd0, done2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
